texture_4_sampler: RTL
======================

Name: texture_4_sampler

Overview:
- Texel fetch stage directly upstream of the texture 4 palette lookup.
- Accepts per-pixel texture coordinate requests from the raycast/render pipeline and applies wrap or clamp addressing.
- Issues reads to the fixed-latency texture 4 index ROM and buffers the returned 8-bit palette indices with backpressure.
- The palette stage consumes the buffered indices, each paired with its pixel tag.

Parameters:
- TEX_LOG2, 5: texture is 2^TEX_LOG2 x 2^TEX_LOG2 texels (default 32x32).
- COORD_W, 8: width of the u/v request coordinates; must be >= TEX_LOG2.
- ROM_LAT, 2: fixed ROM read latency in cycles, >= 1.
- FIFO_DEPTH, 4: output buffer entries, power of two, >= 2.
- TAG_W, 10: width of the opaque pixel tag (screen x) carried alongside each request.

Ports:
- Clk  in  1  system clock; all state on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous drop of all in-flight and buffered work (frame start).
- clamp_en  in  1  1 = clamp addressing, 0 = wrap addressing; sampled with each accepted request.
- req_valid  in  1  request valid.
- req_ready  out  1  request may be accepted this cycle.
- req_u  in  COORD_W  texture column.
- req_v  in  COORD_W  texture row.
- req_tag  in  TAG_W  pixel tag.
- rom_addr  out  2*TEX_LOG2  ROM address, registered, equal to {v_eff, u_eff}.
- rom_data  in  8  ROM palette index, valid ROM_LAT cycles after rom_addr changes.
- idx_valid  out  1  buffered index available.
- idx_ready  in  1  palette stage consumes the head entry.
- idx  out  8  head palette index (show-ahead).
- idx_tag  out  TAG_W  tag of the head entry.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Clears the valid shift pipe, FIFO pointers and occupancy count.
  - rom_addr=0, idx_valid=0, idx=0, idx_tag=0.
  - req_ready=1 in the first cycle after release.
  - Reset mid-operation discards all outstanding requests; no stale entry is ever emitted after release.
- Address calculation (per coordinate c, TEX_SIZE = 2^TEX_LOG2):
  - Wrap: c_eff = c[TEX_LOG2-1:0].
  - Clamp: c_eff = (c >= TEX_SIZE) ? TEX_SIZE-1 : c. Comparison is unsigned.
- Accept and ROM issue:
  - A request is accepted when req_valid && req_ready.
  - At that edge rom_addr is registered and a valid bit plus tag enter stage 0 of a ROM_LAT-deep shift pipe.
  - Without an accept, rom_addr holds its previous value.
- ROM return:
  - At the edge where a valid bit leaves pipe stage ROM_LAT-1, {rom_data, tag} is written to the FIFO.
  - rom_data is sampled at exactly that edge.
  - Writes can never overflow, by the credit rule below.
- Credit rule:
  - count = (valid bits in the pipe) + FIFO occupancy.
  - req_ready = !flush && (count < FIFO_DEPTH), combinational from registered state.
  - An accept and a pop in the same cycle leave count unchanged.
  - A pop in the cycle count == FIFO_DEPTH does not raise req_ready in that same cycle; it rises the next cycle.
- Latency:
  - With an empty FIFO, a request accepted in cycle 0 gives idx_valid=1 in cycle ROM_LAT+1 (cycle 3 by default).
  - Sustained throughput is one index per cycle while idx_ready=1.
- Output:
  - idx_valid = FIFO non-empty.
  - idx/idx_tag show the head entry and hold stable while idx_valid && !idx_ready.
  - Pop on idx_valid && idx_ready.
  - Order is strictly FIFO.
- Simultaneous FIFO write and pop:
  - Both are permitted, including when the FIFO is empty: the written entry appears the next cycle.
  - Simultaneous write and pop with a full FIFO is permitted.
- flush:
  - Clears the pipe valids, FIFO pointers and count at the edge; req_ready=0 during the flush cycle.
  - Any accept or pop attempted in that cycle is ignored.
  - idx_valid=0 in the next cycle.
  - ROM data returning later for flushed requests is dropped.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH; the full/empty decision comes from the occupancy counter, not pointer equality.

Test Plan:
- Reset then single request u=3, v=2, tag=7, wrap → rom_addr=0x043 the cycle after accept; ROM model returns 0xA5; idx_valid rises in cycle 3 with idx=0xA5, idx_tag=7.
- Addressing, u=40, v=33:
  - wrap → u_eff=8, v_eff=1, rom_addr=0x028;
  - clamp → rom_addr=0x3FF;
  - clamp with u=31, v=0 → rom_addr=0x01F.
- Backpressure: idx_ready=0, stream 6 requests → exactly 4 accepted, req_ready=0 from the cycle after the 4th accept; raise idx_ready → indices emerge in order with tags intact, and req_ready returns after the first pop.
- Full throughput: idx_ready=1, 16 back-to-back requests → 16 outputs on consecutive cycles 3..18, req_ready never drops.
- flush with 2 in flight and 2 buffered → idx_valid=0 the next cycle; late ROM returns discarded; next request's index is the only one emitted.
- Assert Reset_n low mid-stream with 3 in flight → all outputs zero immediately; after release req_ready=1 and no stale entries appear.

Source files
------------

// File: rtl/texture_4_sampler.sv
// Texture 4 texel fetch: wrap/clamp addressing, fixed-latency ROM issue and a
// credit-controlled show-ahead FIFO of {palette index, pixel tag} entries.
module texture_4_sampler #(
    parameter int unsigned TEX_LOG2   = 5,
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned ROM_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 10
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  flush,
    input  logic                  clamp_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [COORD_W-1:0]    req_u,
    input  logic [COORD_W-1:0]    req_v,
    input  logic [TAG_W-1:0]      req_tag,
    output logic [2*TEX_LOG2-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  idx_valid,
    input  logic                  idx_ready,
    output logic [7:0]            idx,
    output logic [TAG_W-1:0]      idx_tag
);

    localparam int unsigned TEX_MAX = (1 << TEX_LOG2) - 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + ROM_LAT + 1);

    logic [ROM_LAT-1:0] vld;
    logic [TAG_W-1:0]   tag_pipe [ROM_LAT];
    logic [7:0]         mem_idx  [FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               fifo_wr;
    logic               fifo_rd;

    // Effective texel coordinate: clamp saturates to the last texel, wrap keeps low bits.
    function automatic logic [TEX_LOG2-1:0] coord_eff(input logic [COORD_W-1:0] c,
                                                      input logic clamp);
        if (clamp && (c > COORD_W'(TEX_MAX)))
            return TEX_LOG2'(TEX_MAX);
        return c[TEX_LOG2-1:0];
    endfunction

    // Credit count and handshake decode; all terms come from registered state except flush.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < ROM_LAT; i++)
            count = count + CNT_W'(vld[i]);
        count     = count + CNT_W'(occ);
        req_ready = !flush && (count < CNT_W'(FIFO_DEPTH));
        accept    = req_valid && req_ready;
        idx_valid = (occ != '0);
        fifo_wr   = vld[ROM_LAT-1] && !flush;
        fifo_rd   = idx_valid && idx_ready && !flush;
        idx       = idx_valid ? mem_idx[rd_ptr] : 8'h00;
        idx_tag   = idx_valid ? mem_tag[rd_ptr] : '0;
    end

    // Control state: ROM address, in-flight valid pipe, FIFO pointers and occupancy.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld      <= '0;
            rom_addr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (accept)
                rom_addr <= {coord_eff(req_v, clamp_en), coord_eff(req_u, clamp_en)};
            if (flush) begin
                vld    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                for (int unsigned i = 1; i < ROM_LAT; i++)
                    vld[i] <= vld[i-1];
                vld[0] <= accept;
                if (fifo_wr)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (fifo_rd)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (fifo_wr && !fifo_rd)
                    occ <= occ + OCC_W'(1);
                else if (!fifo_wr && fifo_rd)
                    occ <= occ - OCC_W'(1);
            end
        end
    end

    // Datapath storage: tags travel beside the valid pipe, ROM data captured on pipe exit.
    always_ff @(posedge Clk) begin
        tag_pipe[0] <= req_tag;
        for (int unsigned i = 1; i < ROM_LAT; i++)
            tag_pipe[i] <= tag_pipe[i-1];
        if (fifo_wr) begin
            mem_idx[wr_ptr] <= rom_data;
            mem_tag[wr_ptr] <= tag_pipe[ROM_LAT-1];
        end
    end

endmodule
